// File: rtl/legv8_dmem_pkg.sv
// Shared types for the dual-issue LEGv8 data-memory responder.
// Used by legv8_dmem_responder and dmem_bank.
package legv8_dmem_pkg;

    localparam int DWORD_W = 64;
    localparam int ADDR_W  = 64;

    typedef enum logic {
        ST_ACCEPT,
        ST_REPLAY
    } state_t;

    typedef struct packed {
        logic [ADDR_W-1:0]  addr;
        logic [DWORD_W-1:0] wdata;
        logic               we;
        logic               re;
    } req_t;

    function automatic logic f_active(input req_t r);
        return r.we | r.re;
    endfunction

endpackage

// File: rtl/dmem_bank.sv
// Single-port synchronous doubleword RAM: one read or one write per edge,
// registered read data that holds until the next read.
module dmem_bank
    import legv8_dmem_pkg::*;
#(
    parameter int ROWS  = 128,
    parameter int ROW_W = $clog2(ROWS)
) (
    input  logic               i_clk,
    input  logic               i_en,
    input  logic               i_we,
    input  logic [ROW_W-1:0]   i_row,
    input  logic [DWORD_W-1:0] i_wdata,
    output logic [DWORD_W-1:0] o_rdata
);

    logic [DWORD_W-1:0] r_mem [ROWS];
    logic [DWORD_W-1:0] r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_en) begin
            if (i_we) begin
                r_mem[i_row] <= i_wdata;
            end else begin
                r_rdata <= r_mem[i_row];
            end
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/legv8_dmem_responder.sv
// Dual-port data-memory responder over two doubleword-interleaved banks.
// Optional misaligned-access flagging via `define DMEM_MISALIGN_CHECK_EN.
module legv8_dmem_responder
    import legv8_dmem_pkg::*;
#(
    parameter int DEPTH_DWORDS = 256,
    parameter int ADDR_LSB     = 3
) (
    input  logic               CLOCK,
    input  logic               RESET,
    input  logic [ADDR_W-1:0]  addr1,
    input  logic [DWORD_W-1:0] wdata1,
    input  logic               memwrite1,
    input  logic               memread1,
    input  logic [ADDR_W-1:0]  addr2,
    input  logic [DWORD_W-1:0] wdata2,
    input  logic               memwrite2,
    input  logic               memread2,
    output logic [DWORD_W-1:0] rdata1,
    output logic [DWORD_W-1:0] rdata2,
    output logic               rvalid1,
    output logic               rvalid2,
    output logic               stall
`ifdef DMEM_MISALIGN_CHECK_EN
    ,
    output logic               misalign1,
    output logic               misalign2
`endif
);

    localparam int IDX_W = $clog2(DEPTH_DWORDS);
    localparam int ROW_W = IDX_W - 1;
    localparam int ROWS  = DEPTH_DWORDS / 2;

    state_t             r_state;
    req_t               r_rep;
    logic               r_rv1, r_rv2;
    logic               r_bank1, r_bank2;
    logic [DWORD_W-1:0] r_hold1, r_hold2;

    req_t               w_p1, w_p2, w_s1, w_s2, w_k1, w_k2;
    logic               w_conflict;
    logic [1:0]         w_ben, w_bwe;
    logic [ROW_W-1:0]   w_brow [2];
    logic [DWORD_W-1:0] w_bwd  [2];
    logic [DWORD_W-1:0] w_brd  [2];
    logic               w_unused;

    assign w_p1 = '{addr: addr1, wdata: wdata1, we: memwrite1, re: memread1 & ~memwrite1};
    assign w_p2 = '{addr: addr2, wdata: wdata2, we: memwrite2, re: memread2 & ~memwrite2};

    // Select what each slot services this edge; during REPLAY only the captured port 2 request runs.
    always_comb begin
        w_s1       = '0;
        w_s2       = '0;
        w_conflict = 1'b0;
        if (!RESET) begin
            if (r_state == ST_ACCEPT) begin
                w_conflict = f_active(w_p1) && f_active(w_p2) &&
                             (w_p1.addr[ADDR_LSB] == w_p2.addr[ADDR_LSB]);
                w_s1 = w_p1;
                if (!w_conflict) begin
                    w_s2 = w_p2;
                end
            end else begin
                w_s2 = r_rep;
            end
        end
    end

`ifdef DMEM_MISALIGN_CHECK_EN
    logic w_mis1, w_mis2;
    logic r_mis1, r_mis2;

    assign w_mis1 = f_active(w_s1) && (w_s1.addr[ADDR_LSB-1:0] != '0);
    assign w_mis2 = f_active(w_s2) && (w_s2.addr[ADDR_LSB-1:0] != '0);

    always_comb begin
        w_k1    = w_s1;
        w_k2    = w_s2;
        w_k1.we = w_s1.we & ~w_mis1;
        w_k2.we = w_s2.we & ~w_mis2;
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            r_mis1 <= 1'b0;
            r_mis2 <= 1'b0;
        end else begin
            r_mis1 <= w_mis1;
            r_mis2 <= w_mis2;
        end
    end

    assign misalign1 = r_mis1;
    assign misalign2 = r_mis2;
`else
    assign w_k1 = w_s1;
    assign w_k2 = w_s2;
`endif

    // Serviced slots never share a bank, so each bank sees at most one of them.
    always_comb begin
        for (int b = 0; b < 2; b++) begin
            w_ben[b]  = 1'b0;
            w_bwe[b]  = 1'b0;
            w_brow[b] = '0;
            w_bwd[b]  = '0;
            if (f_active(w_k1) && (w_k1.addr[ADDR_LSB] == b[0])) begin
                w_ben[b]  = 1'b1;
                w_bwe[b]  = w_k1.we;
                w_brow[b] = w_k1.addr[ADDR_LSB+1 +: ROW_W];
                w_bwd[b]  = w_k1.wdata;
            end else if (f_active(w_k2) && (w_k2.addr[ADDR_LSB] == b[0])) begin
                w_ben[b]  = 1'b1;
                w_bwe[b]  = w_k2.we;
                w_brow[b] = w_k2.addr[ADDR_LSB+1 +: ROW_W];
                w_bwd[b]  = w_k2.wdata;
            end
        end
    end

    for (genvar g = 0; g < 2; g++) begin : g_bank
        dmem_bank #(
            .ROWS  (ROWS),
            .ROW_W (ROW_W)
        ) u_bank (
            .i_clk   (CLOCK),
            .i_en    (w_ben[g]),
            .i_we    (w_bwe[g]),
            .i_row   (w_brow[g]),
            .i_wdata (w_bwd[g]),
            .o_rdata (w_brd[g])
        );
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            r_state <= ST_ACCEPT;
            r_rv1   <= 1'b0;
            r_rv2   <= 1'b0;
            r_hold1 <= '0;
            r_hold2 <= '0;
        end else begin
            r_rv1 <= w_k1.re;
            r_rv2 <= w_k2.re;
            if (r_rv1) begin
                r_hold1 <= w_brd[r_bank1];
            end
            if (r_rv2) begin
                r_hold2 <= w_brd[r_bank2];
            end
            case (r_state)
                ST_ACCEPT: r_state <= w_conflict ? ST_REPLAY : ST_ACCEPT;
                default:   r_state <= ST_ACCEPT;
            endcase
        end
    end

    always_ff @(posedge CLOCK) begin
        r_bank1 <= w_k1.addr[ADDR_LSB];
        r_bank2 <= w_k2.addr[ADDR_LSB];
        if (w_conflict) begin
            r_rep <= w_p2;
        end
    end

    // Fresh bank data is forwarded in the return cycle; the hold register covers idle cycles.
    assign rdata1  = r_rv1 ? w_brd[r_bank1] : r_hold1;
    assign rdata2  = r_rv2 ? w_brd[r_bank2] : r_hold2;
    assign rvalid1 = r_rv1;
    assign rvalid2 = r_rv2;
    assign stall   = w_conflict;

    assign w_unused = ^{w_k1.addr, w_k2.addr};

endmodule

// File: tb/tb_legv8_dmem_responder.sv
// Testbench for legv8_dmem_responder: directed vector table, hand sequences
// and randomized traffic against a flat-array reference model.
module tb_legv8_dmem_responder;

    localparam int DEPTH = 256;
`ifdef DMEM_MISALIGN_CHECK_EN
    localparam bit MIS_EN = 1'b1;
`else
    localparam bit MIS_EN = 1'b0;
`endif

    logic        CLOCK = 1'b0;
    logic        RESET;
    logic [63:0] addr1, wdata1, addr2, wdata2;
    logic        memwrite1, memread1, memwrite2, memread2;
    logic [63:0] rdata1, rdata2;
    logic        rvalid1, rvalid2, stall;
`ifdef DMEM_MISALIGN_CHECK_EN
    logic        misalign1, misalign2;
`endif

    always #5 CLOCK = ~CLOCK;

    legv8_dmem_responder #(
        .DEPTH_DWORDS (DEPTH),
        .ADDR_LSB     (3)
    ) dut (
        .CLOCK     (CLOCK),
        .RESET     (RESET),
        .addr1     (addr1),
        .wdata1    (wdata1),
        .memwrite1 (memwrite1),
        .memread1  (memread1),
        .addr2     (addr2),
        .wdata2    (wdata2),
        .memwrite2 (memwrite2),
        .memread2  (memread2),
        .rdata1    (rdata1),
        .rdata2    (rdata2),
        .rvalid1   (rvalid1),
        .rvalid2   (rvalid2),
        .stall     (stall)
`ifdef DMEM_MISALIGN_CHECK_EN
        ,
        .misalign1 (misalign1),
        .misalign2 (misalign2)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: flat memory, one deferred port-2 request, expected visible outputs.
    logic [63:0] m_mem [DEPTH];
    bit          m_pend;
    bit          m_conf;
    logic [63:0] m_pa, m_pwd;
    bit          m_pw, m_pr;
    logic [63:0] e_rd1, e_rd2;
    bit          e_rv1, e_rv2, e_mis1, e_mis2;

    typedef struct {
        bit          mw1, mr1;
        logic [63:0] a1, wd1;
        bit          mw2, mr2;
        logic [63:0] a2, wd2;
        bit          x_stall, x_rv1, x_rv2;
        logic [63:0] x_rd1, x_rd2;
    } vec_t;

    vec_t tbl [17];

    function automatic vec_t mk(input bit mw1, input bit mr1, input logic [63:0] a1, input logic [63:0] wd1,
                                input bit mw2, input bit mr2, input logic [63:0] a2, input logic [63:0] wd2,
                                input bit s, input bit rv1, input bit rv2,
                                input logic [63:0] rd1, input logic [63:0] rd2);
        vec_t v;
        v.mw1 = mw1; v.mr1 = mr1; v.a1 = a1; v.wd1 = wd1;
        v.mw2 = mw2; v.mr2 = mr2; v.a2 = a2; v.wd2 = wd2;
        v.x_stall = s; v.x_rv1 = rv1; v.x_rv2 = rv2; v.x_rd1 = rd1; v.x_rd2 = rd2;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic m_serve(input int port, input logic [63:0] a, input logic [63:0] wd, input bit w, input bit r);
        int idx;
        bit mis;
        if (!(w || r)) return;
        idx = int'((a >> 3) % DEPTH);
        mis = MIS_EN && (a[2:0] != 3'b000);
        if (w) begin
            if (!mis) m_mem[idx] = wd;
        end else if (port == 1) begin
            e_rd1 = m_mem[idx];
            e_rv1 = 1'b1;
        end else begin
            e_rd2 = m_mem[idx];
            e_rv2 = 1'b1;
        end
        if (port == 1) e_mis1 = mis;
        else           e_mis2 = mis;
    endtask

    // Drive one cycle's inputs and compare the visible outputs against the model.
    task automatic apply(input bit rst, input bit mw1, input bit mr1, input logic [63:0] a1, input logic [63:0] wd1,
                         input bit mw2, input bit mr2, input logic [63:0] a2, input logic [63:0] wd2);
        RESET = rst;
        memwrite1 = mw1; memread1 = mr1; addr1 = a1; wdata1 = wd1;
        memwrite2 = mw2; memread2 = mr2; addr2 = a2; wdata2 = wd2;
        #1;
        m_conf = !rst && !m_pend && (mw1 || mr1) && (mw2 || mr2) && (((a1 >> 3) & 1) == ((a2 >> 3) & 1));
        check("stall", 64'(stall), 64'(m_conf));
        check("rvalid1", 64'(rvalid1), 64'(e_rv1));
        check("rvalid2", 64'(rvalid2), 64'(e_rv2));
        check("rdata1", rdata1, e_rd1);
        check("rdata2", rdata2, e_rd2);
`ifdef DMEM_MISALIGN_CHECK_EN
        check("misalign1", 64'(misalign1), 64'(e_mis1));
        check("misalign2", 64'(misalign2), 64'(e_mis2));
`endif
    endtask

    task automatic tick();
        if (RESET) begin
            m_pend = 1'b0;
            e_rv1 = 1'b0; e_rv2 = 1'b0; e_rd1 = '0; e_rd2 = '0; e_mis1 = 1'b0; e_mis2 = 1'b0;
        end else begin
            e_rv1 = 1'b0; e_rv2 = 1'b0; e_mis1 = 1'b0; e_mis2 = 1'b0;
            if (m_pend) begin
                m_pend = 1'b0;
                m_serve(2, m_pa, m_pwd, m_pw, m_pr);
            end else begin
                m_serve(1, addr1, wdata1, memwrite1, memread1);
                if (m_conf) begin
                    m_pend = 1'b1;
                    m_pa = addr2; m_pwd = wdata2; m_pw = memwrite2; m_pr = memread2;
                end else begin
                    m_serve(2, addr2, wdata2, memwrite2, memread2);
                end
            end
        end
        @(posedge CLOCK);
        #1;
    endtask

    task automatic idle();
        apply(1'b0, 1'b0, 1'b0, 64'h0, 64'h0, 1'b0, 1'b0, 64'h0, 64'h0);
    endtask

    initial begin
        RESET = 1'b1;
        memwrite1 = 1'b0; memread1 = 1'b0; addr1 = '0; wdata1 = '0;
        memwrite2 = 1'b0; memread2 = 1'b0; addr2 = '0; wdata2 = '0;
        m_pend = 1'b0; m_conf = 1'b0; m_pa = '0; m_pwd = '0; m_pw = 1'b0; m_pr = 1'b0;
        e_rv1 = 1'b0; e_rv2 = 1'b0; e_rd1 = '0; e_rd2 = '0; e_mis1 = 1'b0; e_mis2 = 1'b0;
        repeat (2) @(posedge CLOCK);
        #1;

        for (int i = 0; i < 5; i++) tbl[i] = mk(0,0,64'h0,64'h0, 0,0,64'h0,64'h0, 0,0,0,64'h0,64'h0);
        tbl[5]  = mk(1,0,64'h00,64'hAAAA, 1,0,64'h08,64'h5555, 0,0,0,64'h0,64'h0);
        tbl[6]  = mk(0,1,64'h08,64'h0,    0,1,64'h00,64'h0,    0,0,0,64'h0,64'h0);
        tbl[7]  = mk(0,0,64'h0,64'h0,     0,0,64'h0,64'h0,     0,1,1,64'h5555,64'hAAAA);
        tbl[8]  = mk(1,0,64'h10,64'h1234, 0,1,64'h10,64'h0,    1,0,0,64'h5555,64'hAAAA);
        tbl[9]  = mk(1,0,64'h10,64'h1234, 0,1,64'h10,64'h0,    0,0,0,64'h5555,64'hAAAA);
        tbl[10] = mk(0,0,64'h0,64'h0,     0,0,64'h0,64'h0,     0,0,1,64'h5555,64'h1234);
        tbl[11] = mk(1,0,64'h20,64'h1,    1,0,64'h20,64'h2,    1,0,0,64'h5555,64'h1234);
        tbl[12] = mk(1,0,64'h20,64'h1,    1,0,64'h20,64'h2,    0,0,0,64'h5555,64'h1234);
        tbl[13] = mk(0,1,64'h20,64'h0,    0,0,64'h0,64'h0,     0,0,0,64'h5555,64'h1234);
        tbl[14] = mk(0,0,64'h0,64'h0,     0,0,64'h0,64'h0,     0,1,0,64'h2,64'h1234);
        tbl[15] = mk(1,0,64'h30,64'h7,    0,0,64'h0,64'h0,     0,0,0,64'h2,64'h1234);
        tbl[16] = mk(0,0,64'h0,64'h0,     0,0,64'h0,64'h0,     0,0,0,64'h2,64'h1234);

        RESET = 1'b0;
        for (int i = 0; i < 17; i++) begin
            apply(1'b0, tbl[i].mw1, tbl[i].mr1, tbl[i].a1, tbl[i].wd1,
                  tbl[i].mw2, tbl[i].mr2, tbl[i].a2, tbl[i].wd2);
            check($sformatf("tbl%0d_stall", i), 64'(stall), 64'(tbl[i].x_stall));
            check($sformatf("tbl%0d_rvalid1", i), 64'(rvalid1), 64'(tbl[i].x_rv1));
            check($sformatf("tbl%0d_rvalid2", i), 64'(rvalid2), 64'(tbl[i].x_rv2));
            check($sformatf("tbl%0d_rdata1", i), rdata1, tbl[i].x_rd1);
            check($sformatf("tbl%0d_rdata2", i), rdata2, tbl[i].x_rd2);
            tick();
        end

        // Reset lands on the replay cycle of a deferred port 2 store.
        apply(1'b0, 1'b0, 1'b1, 64'h20, 64'h0, 1'b1, 1'b0, 64'h30, 64'hFFFF);
        check("rst_replay_stall", 64'(stall), 64'h1);
        tick();
        apply(1'b1, 1'b0, 1'b1, 64'h20, 64'h0, 1'b1, 1'b0, 64'h30, 64'hFFFF);
        tick();
        idle();
        check("rst_replay_rv1", 64'(rvalid1), 64'h0);
        check("rst_replay_rv2", 64'(rvalid2), 64'h0);
        check("rst_replay_rd1", rdata1, 64'h0);
        check("rst_replay_rd2", rdata2, 64'h0);
        tick();
        apply(1'b0, 1'b0, 1'b1, 64'h30, 64'h0, 1'b1, 1'b0, 64'h38, 64'h99);
        check("post_rst_accept", 64'(stall), 64'h0);
        tick();
        idle();
        check("rst_dropped_store", rdata1, 64'h7);
        check("rst_dropped_rv1", 64'(rvalid1), 64'h1);
        tick();

`ifdef DMEM_MISALIGN_CHECK_EN
        apply(1'b0, 1'b1, 1'b0, 64'h40, 64'h99, 1'b0, 1'b0, 64'h0, 64'h0);
        tick();
        apply(1'b0, 1'b1, 1'b0, 64'h44, 64'hBEEF, 1'b0, 1'b0, 64'h0, 64'h0);
        tick();
        apply(1'b0, 1'b0, 1'b1, 64'h40, 64'h0, 1'b0, 1'b0, 64'h0, 64'h0);
        check("mis_flag1", 64'(misalign1), 64'h1);
        tick();
        idle();
        check("mis_store_suppressed", rdata1, 64'h99);
        check("mis_flag1_clear", 64'(misalign1), 64'h0);
        tick();
`endif

        // Prefill the random working set so every load has a defined value.
        for (int k = 0; k < 8; k++) begin
            apply(1'b0, 1'b1, 1'b0, 64'(2*k) << 3, {$urandom, $urandom},
                  1'b1, 1'b0, 64'(2*k+1) << 3, {$urandom, $urandom});
            tick();
        end

        for (int i = 0; i < 600; i++) begin
            logic [63:0] ra1, ra2;
            bit          rr;
            rr  = ($urandom_range(0, 49) == 0);
            ra1 = ({$urandom, $urandom} & ~64'h7FF) | (64'($urandom_range(0, 15)) << 3) |
                  (($urandom_range(0, 3) == 0) ? 64'($urandom_range(0, 7)) : 64'h0);
            ra2 = ({$urandom, $urandom} & ~64'h7FF) | (64'($urandom_range(0, 15)) << 3) |
                  (($urandom_range(0, 3) == 0) ? 64'($urandom_range(0, 7)) : 64'h0);
            apply(rr, ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0), ra1, {$urandom, $urandom},
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0), ra2, {$urandom, $urandom});
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
